hazard_stall_unit: RTL

- Source end of the pipeline's stall/flush request path for the 5-stage pipelined CPU.
- Detects three hazards and drives the per-stage write-enable and flush controls that the downstream OR gating combines:
  - load-use,
  - multi-cycle multiply/divide occupancy,
  - taken branch resolved in EX.
- Tracks multiply/divide busy time with an internal counter FSM and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_stall_unit_pkg.sv | 31 +++
 rtl/hazard_stall_unit_md_busy_tracker.sv | 57 +++++
 rtl/hazard_stall_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall control slice.
package hazard_stall_unit_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned MD_CNT_W = 4;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_LOAD_USE,
    HZ_MD,
    HZ_BRANCH
  } hazard_cause_t;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RESET  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
  localparam pipe_ctrl_t CTRL_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};

endpackage

// File: rtl/hazard_stall_unit_md_busy_tracker.sv
// Mult/div occupancy tracker: IDLE/BUSY FSM with a down-counter loaded on issue.
module md_busy_tracker
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic md_busy
);

  md_state_t             r_state;
  md_state_t             w_state_next;
  logic [MD_CNT_W-1:0]   r_cnt;
  logic [MD_CNT_W-1:0]   w_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Counter loads LATENCY-1 and BUSY lasts one extra cycle at zero, giving LATENCY busy cycles.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      MD_IDLE: begin
        if (issue) begin
          w_state_next = MD_BUSY;
          w_cnt_next   = MD_CNT_W'(MD_LATENCY - 1);
        end
      end
      MD_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - MD_CNT_W'(1);
        end else begin
          w_state_next = MD_IDLE;
        end
      end
      default: begin
        w_state_next = MD_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    md_busy = (r_state == MD_BUSY);
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush request source: load-use, mult/div occupancy and taken-branch hazards.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  id_md_start,
  input  logic                  id_md_read,
  output logic                  pc_we,
  output logic                  ifid_we,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  md_busy,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic          w_load_use;
  logic          w_md_hazard;
  logic          w_stall;
  logic          w_issue;
  hazard_cause_t w_cause;
  pipe_ctrl_t    w_ctrl;
  logic [CNT_W-1:0] r_stall_cnt;

  always_comb begin
    w_load_use = ex_mem_read
              && (ex_rt != REG_ADDR_W'(REG_ZERO))
              && ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
    w_md_hazard = md_busy && (id_md_start || id_md_read);
    w_stall     = w_load_use || w_md_hazard;
    w_issue     = id_md_start && !w_stall && !ex_branch_taken;
  end

  md_busy_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_busy_tracker (
    .clk    (clk),
    .rst    (rst),
    .issue  (w_issue),
    .md_busy(md_busy)
  );

  always_comb begin
    if (ex_branch_taken) begin
      w_cause = HZ_BRANCH;
    end else if (w_load_use) begin
      w_cause = HZ_LOAD_USE;
    end else if (w_md_hazard) begin
      w_cause = HZ_MD;
    end else begin
      w_cause = HZ_NONE;
    end
  end

  always_comb begin
    w_ctrl = CTRL_RUN;
    if (rst) begin
      w_ctrl = CTRL_RESET;
    end else begin
      unique case (w_cause)
        HZ_BRANCH:          w_ctrl = CTRL_BRANCH;
        HZ_LOAD_USE, HZ_MD: w_ctrl = CTRL_STALL;
        default:            w_ctrl = CTRL_RUN;
      endcase
    end
  end

  always_comb begin
    pc_we      = w_ctrl.pc_we;
    ifid_we    = w_ctrl.ifid_we;
    ifid_flush = w_ctrl.ifid_flush;
    idex_flush = w_ctrl.idex_flush;
    stall_cnt  = r_stall_cnt;
  end

  // Only stalls that actually hold the pipe are counted; branch-overridden ones are not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (((w_cause == HZ_LOAD_USE) || (w_cause == HZ_MD)) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule
